// File: rtl/irq_entry_seq_if.sv
// irq_entry_seq_if
//   Groups the interrupt handshake and the system bus signals of the CPU-side
//   interrupt entry sequencer.
//   master : the sequencer (drives iack and the bus strobes/address/data)
//   slave  : the interrupt controller / bus arbiter side
//   Signals:
//     cpu_irq          request level (bit0 = NMI, bits[3:1] = levels 1..3)
//     cpu_iack         interrupt acknowledge strobe
//     bus_address_out  24-bit bus address
//     bus_data_in      bus read data (vector byte during the iack cycle)
//     bus_data_out     stack write data
//     bus_read         read strobe
//     bus_write        write strobe
//     bus_wait         holds the current bus cycle while high
interface irq_entry_seq_if;
    logic [3:0]  cpu_irq;
    logic        cpu_iack;
    logic [23:0] bus_address_out;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        bus_read;
    logic        bus_write;
    logic        bus_wait;

    modport master (
        input  cpu_irq,
        input  bus_data_in,
        input  bus_wait,
        output cpu_iack,
        output bus_address_out,
        output bus_data_out,
        output bus_read,
        output bus_write
    );

    modport slave (
        output cpu_irq,
        output bus_data_in,
        output bus_wait,
        input  cpu_iack,
        input  bus_address_out,
        input  bus_data_out,
        input  bus_read,
        input  bus_write
    );
endinterface

// File: rtl/irq_entry_seq.sv
// irq_entry_seq
//   CPU-side interrupt entry sequencer. At an instruction boundary it accepts
//   a pending request whose level beats the status-register mask (or an NMI),
//   runs the acknowledge cycle to get the vector, pushes CB (optional), PC and
//   SC onto the stack, fetches the 16-bit handler address and commits the new
//   PC/SP/SC to the core with one-cycle write enables.
//   Ports:
//     clk, reset              clock, asynchronous active-high reset
//     instr_boundary          core is between instructions
//     bus                     irq handshake + system bus (master modport)
//     sc_in/pc_in/sp_in/cb_in current core status, PC, SP, code bank
//     busy                    sequence in progress
//     pc_out/pc_we            new PC and its load strobe
//     sp_out/sp_we            new SP and its load strobe
//     sc_out/sc_we            new SC and its load strobe
module irq_entry_seq #(
    parameter int unsigned PUSH_CB     = 1,
    parameter logic [7:0]  VECTOR_PAGE = 8'h00,
    parameter logic [7:0]  STACK_PAGE  = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_boundary,
    irq_entry_seq_if.master        bus,
    input  logic [7:0]             sc_in,
    input  logic [15:0]            pc_in,
    input  logic [15:0]            sp_in,
    input  logic [7:0]             cb_in,
    output logic                   busy,
    output logic [15:0]            pc_out,
    output logic                   pc_we,
    output logic [15:0]            sp_out,
    output logic                   sp_we,
    output logic [7:0]             sc_out,
    output logic                   sc_we
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACK,
        ST_PUSH_CB,
        ST_PUSH_PCH,
        ST_PUSH_PCL,
        ST_PUSH_SC,
        ST_VEC_LO,
        ST_VEC_HI,
        ST_COMMIT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [2:0]  irq_level;
    logic        accept;
    logic        bus_step;

    logic [15:0] pc_q;
    logic [15:0] sp_q;
    logic [7:0]  sc_q;
    logic [7:0]  cb_q;
    logic [2:0]  level_q;
    logic [7:0]  vec_q;
    logic [7:0]  vec_lo_q;
    logic [7:0]  vec_hi_q;

    logic [15:0] sp_dec;
    logic [1:0]  new_mask;

    // NMI decodes as level 4 so it always beats the 2-bit mask.
    always_comb begin
        irq_level = 3'd0;
        if (bus.cpu_irq[0]) begin
            irq_level = 3'd4;
        end else if (bus.cpu_irq[3]) begin
            irq_level = 3'd3;
        end else if (bus.cpu_irq[2]) begin
            irq_level = 3'd2;
        end else if (bus.cpu_irq[1]) begin
            irq_level = 3'd1;
        end
    end

    assign accept   = (state == ST_IDLE) && instr_boundary &&
                      ((irq_level == 3'd4) || (irq_level > {1'b0, sc_in[7:6]}));
    assign bus_step = !bus.bus_wait;
    assign sp_dec   = sp_q - 16'd1;
    assign new_mask = (level_q == 3'd4) ? 2'b11 : level_q[1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; every bus state holds while bus_wait is high.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (bus_step) begin
                    state_next = (PUSH_CB != 0) ? ST_PUSH_CB : ST_PUSH_PCH;
                end
            end
            ST_PUSH_CB:  if (bus_step) state_next = ST_PUSH_PCH;
            ST_PUSH_PCH: if (bus_step) state_next = ST_PUSH_PCL;
            ST_PUSH_PCL: if (bus_step) state_next = ST_PUSH_SC;
            ST_PUSH_SC:  if (bus_step) state_next = ST_VEC_LO;
            ST_VEC_LO:   if (bus_step) state_next = ST_VEC_HI;
            ST_VEC_HI:   if (bus_step) state_next = ST_COMMIT;
            ST_COMMIT:   state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Context latches. SP only moves when a push actually completes, so a
    // waited push performs a single decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            sp_q     <= '0;
            sc_q     <= '0;
            cb_q     <= '0;
            level_q  <= '0;
            vec_q    <= '0;
            vec_lo_q <= '0;
            vec_hi_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pc_q    <= pc_in;
                        sp_q    <= sp_in;
                        sc_q    <= sc_in;
                        cb_q    <= cb_in;
                        level_q <= irq_level;
                    end
                end
                ST_ACK: begin
                    if (bus_step) begin
                        vec_q <= bus.bus_data_in & 8'hFE;
                    end
                end
                ST_PUSH_CB, ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_SC: begin
                    if (bus_step) begin
                        sp_q <= sp_dec;
                    end
                end
                ST_VEC_LO: begin
                    if (bus_step) begin
                        vec_lo_q <= bus.bus_data_in;
                    end
                end
                ST_VEC_HI: begin
                    if (bus_step) begin
                        vec_hi_q <= bus.bus_data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state and latches only, so an async reset
    // clears them immediately and they stay stable across wait cycles.
    always_comb begin
        busy                = (state != ST_IDLE);
        bus.cpu_iack        = 1'b0;
        bus.bus_read        = 1'b0;
        bus.bus_write       = 1'b0;
        bus.bus_address_out = '0;
        bus.bus_data_out    = '0;
        pc_out              = '0;
        pc_we               = 1'b0;
        sp_out              = '0;
        sp_we               = 1'b0;
        sc_out              = '0;
        sc_we               = 1'b0;
        case (state)
            ST_ACK: begin
                bus.cpu_iack = 1'b1;
                bus.bus_read = 1'b1;
            end
            ST_PUSH_CB: begin
                bus.bus_write       = 1'b1;
                bus.bus_address_out = {STACK_PAGE, sp_dec};
                bus.bus_data_out    = cb_q;
            end
            ST_PUSH_PCH: begin
                bus.bus_write       = 1'b1;
                bus.bus_address_out = {STACK_PAGE, sp_dec};
                bus.bus_data_out    = pc_q[15:8];
            end
            ST_PUSH_PCL: begin
                bus.bus_write       = 1'b1;
                bus.bus_address_out = {STACK_PAGE, sp_dec};
                bus.bus_data_out    = pc_q[7:0];
            end
            ST_PUSH_SC: begin
                bus.bus_write       = 1'b1;
                bus.bus_address_out = {STACK_PAGE, sp_dec};
                bus.bus_data_out    = sc_q;
            end
            ST_VEC_LO: begin
                bus.bus_read        = 1'b1;
                bus.bus_address_out = {VECTOR_PAGE, 8'h00, vec_q};
            end
            ST_VEC_HI: begin
                // vec is even, so setting bit0 is the +1 with no carry.
                bus.bus_read        = 1'b1;
                bus.bus_address_out = {VECTOR_PAGE, 8'h00, vec_q | 8'h01};
            end
            ST_COMMIT: begin
                pc_out = {vec_hi_q, vec_lo_q};
                pc_we  = 1'b1;
                sp_out = sp_q;
                sp_we  = 1'b1;
                sc_out = {new_mask, sc_q[5:0]};
                sc_we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_irq_entry_seq.sv
// tb_irq_entry_seq
//   Self-checking bench for irq_entry_seq. Two instances: dut (PUSH_CB=1)
//   and dut0 (PUSH_CB=0). Expected bus writes, reads and commits are queued
//   when a request is issued and popped as the selected DUT produces them.
module tb_irq_entry_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_boundary;
    logic        ib0;
    logic [7:0]  sc_in;
    logic [15:0] pc_in;
    logic [15:0] sp_in;
    logic [7:0]  cb_in;

    logic        busy, pc_we, sp_we, sc_we;
    logic [15:0] pc_out, sp_out;
    logic [7:0]  sc_out;
    logic        busy0, pc_we0, sp_we0, sc_we0;
    logic [15:0] pc_out0, sp_out0;
    logic [7:0]  sc_out0;

    logic [7:0]  mem [256];
    logic [7:0]  iack_data;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        int unsigned kind;   // 1 write, 2 read, 3 commit
        logic [23:0] addr;
        logic [7:0]  data;
        logic [15:0] pc;
        logic [15:0] sp;
        logic [7:0]  sc;
    } ev_t;

    ev_t exp_q[$];

    irq_entry_seq_if bi();
    irq_entry_seq_if bi0();

    assign bi.bus_data_in  = bi.cpu_iack  ? iack_data : mem[bi.bus_address_out[7:0]];
    assign bi0.bus_data_in = bi0.cpu_iack ? iack_data : mem[bi0.bus_address_out[7:0]];

    always #5 clk = ~clk;

    irq_entry_seq #(.PUSH_CB(1), .VECTOR_PAGE(8'h00), .STACK_PAGE(8'h00)) dut (
        .clk(clk), .reset(reset), .instr_boundary(instr_boundary), .bus(bi.master),
        .sc_in(sc_in), .pc_in(pc_in), .sp_in(sp_in), .cb_in(cb_in),
        .busy(busy), .pc_out(pc_out), .pc_we(pc_we), .sp_out(sp_out), .sp_we(sp_we),
        .sc_out(sc_out), .sc_we(sc_we)
    );

    irq_entry_seq #(.PUSH_CB(0), .VECTOR_PAGE(8'h00), .STACK_PAGE(8'h00)) dut0 (
        .clk(clk), .reset(reset), .instr_boundary(ib0), .bus(bi0.master),
        .sc_in(sc_in), .pc_in(pc_in), .sp_in(sp_in), .cb_in(cb_in),
        .busy(busy0), .pc_out(pc_out0), .pc_we(pc_we0), .sp_out(sp_out0), .sp_we(sp_we0),
        .sc_out(sc_out0), .sc_we(sc_we0)
    );

    task automatic push_ev(input int unsigned k, input logic [23:0] a, input logic [7:0] d,
                           input logic [15:0] p, input logic [15:0] s, input logic [7:0] c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.pc = p; e.sp = s; e.sc = c;
        exp_q.push_back(e);
    endtask

    // Reference model of one complete entry sequence.
    task automatic expect_seq(input bit pushcb, input logic [15:0] pc, input logic [15:0] sp,
                              input logic [7:0] sc, input logic [7:0] cb,
                              input int unsigned lvl, input logic [7:0] iack);
        logic [15:0] s;
        logic [7:0]  v;
        logic [7:0]  v1;
        logic [1:0]  m;
        s = sp;
        v = iack & 8'hFE;
        v1 = v + 8'd1;
        m = (lvl >= 3) ? 2'b11 : 2'(lvl);
        if (pushcb) begin
            s = s - 16'd1;
            push_ev(1, {8'h00, s}, cb, '0, '0, '0);
        end
        s = s - 16'd1; push_ev(1, {8'h00, s}, pc[15:8], '0, '0, '0);
        s = s - 16'd1; push_ev(1, {8'h00, s}, pc[7:0], '0, '0, '0);
        s = s - 16'd1; push_ev(1, {8'h00, s}, sc, '0, '0, '0);
        push_ev(2, {16'h0000, v}, '0, '0, '0, '0);
        push_ev(2, {16'h0000, v1}, '0, '0, '0, '0);
        push_ev(3, '0, '0, {mem[v1], mem[v]}, s, {m, sc[5:0]});
    endtask

    task automatic issue(input bit sel, input logic [3:0] irq, input bit hold);
        @(negedge clk);
        if (sel) begin
            bi0.cpu_irq = irq; ib0 = 1'b1;
        end else begin
            bi.cpu_irq = irq; instr_boundary = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            ib0 = 1'b0; instr_boundary = 1'b0;
        end
    endtask

    // Steps the selected DUT cycle by cycle from the ACK cycle (n=1), scoring
    // completed bus cycles and the commit against the queue.
    task automatic run_and_score(input bit sel, input int unsigned wait_at,
                                 input int unsigned wait_len, input int unsigned stop_at,
                                 output int unsigned commit_n);
        int unsigned n;
        bit done, stopped, wv, held;
        logic rd, wr, pw, sw, cw, bz;
        logic [23:0] ad, ha;
        logic [7:0]  dt, hd, co;
        logic [15:0] po, so;
        int unsigned k;
        ev_t e;
        n = 0; done = 0; stopped = 0; held = 0; ha = '0; hd = '0;
        commit_n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (stop_at != 0 && n == stop_at) begin
                stopped = 1; done = 1;
            end else begin
                wv = (wait_len != 0) && (n >= wait_at) && (n < wait_at + wait_len);
                if (sel) bi0.bus_wait = wv; else bi.bus_wait = wv;
                #1;
                if (sel) begin
                    rd = bi0.bus_read; wr = bi0.bus_write; ad = bi0.bus_address_out;
                    dt = bi0.bus_data_out; bz = busy0; pw = pc_we0; sw = sp_we0; cw = sc_we0;
                    po = pc_out0; so = sp_out0; co = sc_out0;
                end else begin
                    rd = bi.bus_read; wr = bi.bus_write; ad = bi.bus_address_out;
                    dt = bi.bus_data_out; bz = busy; pw = pc_we; sw = sp_we; cw = sc_we;
                    po = pc_out; so = sp_out; co = sc_out;
                end
                n_checks++;
                if (bz !== 1'b1) $display("FAIL busy_in_seq: cycle %0d busy=%b expected 1", n, bz);
                else n_pass++;
                if (held) begin
                    n_checks++;
                    if (ad !== ha || dt !== hd)
                        $display("FAIL wait_hold: addr=%h data=%h expected addr=%h data=%h", ad, dt, ha, hd);
                    else n_pass++;
                end
                held = wv; ha = ad; hd = dt;
                if (!wv && (wr || rd) && !(rd && (sel ? bi0.cpu_iack : bi.cpu_iack))) begin
                    k = wr ? 1 : 2;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL bus_extra: kind=%0d addr=%h data=%h expected none", k, ad, dt);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.addr !== ad || (k == 1 && e.data !== dt))
                            $display("FAIL bus_cycle: kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                                     k, ad, dt, e.kind, e.addr, e.data);
                        else n_pass++;
                    end
                end
                if (pw || sw || cw) begin
                    commit_n = n; done = 1;
                    n_checks++;
                    if ({pw, sw, cw} !== 3'b111) $display("FAIL commit_we: we=%b expected 111", {pw, sw, cw});
                    else n_pass++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL commit_extra: pc=%h sp=%h sc=%h expected none", po, so, co);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != 3 || e.pc !== po || e.sp !== so || e.sc !== co)
                            $display("FAIL commit_val: pc=%h sp=%h sc=%h expected kind=%0d pc=%h sp=%h sc=%h",
                                     po, so, co, e.kind, e.pc, e.sp, e.sc);
                        else n_pass++;
                    end
                end
            end
        end
        if (!stopped) begin
            if (!done) begin
                n_checks++;
                $display("FAIL seq_timeout: no commit after %0d cycles expected commit", n);
            end
            n_checks++;
            if (exp_q.size() != 0) $display("FAIL queue_left: %0d events expected 0", exp_q.size());
            else n_pass++;
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || busy0 !== 1'b0) $display("FAIL reset_busy: %b%b expected 00", busy, busy0);
        else n_pass++;
        n_checks++;
        if ({bi.cpu_iack, bi.bus_read, bi.bus_write, bi.bus_address_out, bi.bus_data_out} !== '0)
            $display("FAIL reset_bus: addr=%h data=%h strobes=%b expected all 0", bi.bus_address_out,
                     bi.bus_data_out, {bi.cpu_iack, bi.bus_read, bi.bus_write});
        else n_pass++;
        n_checks++;
        if ({pc_out, sp_out, sc_out, pc_we, sp_we, sc_we} !== '0)
            $display("FAIL reset_regs: pc=%h sp=%h sc=%h we=%b expected all 0", pc_out, sp_out, sc_out,
                     {pc_we, sp_we, sc_we});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_maskable();
        int unsigned cn;
        sc_in = 8'h40; pc_in = 16'h1234; sp_in = 16'h2000; cb_in = 8'h05;
        iack_data = 8'h09; mem[8'h08] = 8'hCD; mem[8'h09] = 8'hAB;
        push_ev(1, 24'h001FFF, 8'h05, '0, '0, '0);
        push_ev(1, 24'h001FFE, 8'h12, '0, '0, '0);
        push_ev(1, 24'h001FFD, 8'h34, '0, '0, '0);
        push_ev(1, 24'h001FFC, 8'h40, '0, '0, '0);
        push_ev(2, 24'h000008, '0, '0, '0, '0);
        push_ev(2, 24'h000009, '0, '0, '0, '0);
        push_ev(3, '0, '0, 16'hABCD, 16'h1FFC, 8'hC0);
        issue(0, 4'b1000, 0);
        run_and_score(0, 0, 0, 0, cn);
        n_checks++;
        if (cn != 8) $display("FAIL latency_main: %0d expected 8", cn);
        else n_pass++;
    endtask

    task automatic test_masking();
        int unsigned cn;
        logic [7:0] scs [3] = '{8'hC0, 8'h80, 8'h00};
        logic [3:0] irqs [3] = '{4'b1000, 4'b0100, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sc_in = scs[i]; bi.cpu_irq = irqs[i]; instr_boundary = 1'b1;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                n_checks++;
                if (busy !== 1'b0) $display("FAIL masked_busy: case %0d busy=%b expected 0", i, busy);
                else n_pass++;
            end
            instr_boundary = 1'b0;
        end
        sc_in = 8'hC0; pc_in = 16'h4000; sp_in = 16'h8000; cb_in = 8'h03;
        iack_data = 8'h21; mem[8'h20] = 8'h78; mem[8'h21] = 8'h56;
        expect_seq(1, 16'h4000, 16'h8000, 8'hC0, 8'h03, 4, 8'h21);
        issue(0, 4'b0001, 0);
        run_and_score(0, 0, 0, 0, cn);
        n_checks++;
        if (cn != 8) $display("FAIL latency_nmi: %0d expected 8", cn);
        else n_pass++;
    endtask

    task automatic test_sp_wrap();
        int unsigned cn;
        sc_in = 8'h00; pc_in = 16'hBEEF; sp_in = 16'h0002; cb_in = 8'h07;
        iack_data = 8'h10; mem[8'h10] = 8'h11; mem[8'h11] = 8'h22;
        push_ev(1, 24'h000001, 8'h07, '0, '0, '0);
        push_ev(1, 24'h000000, 8'hBE, '0, '0, '0);
        push_ev(1, 24'h00FFFF, 8'hEF, '0, '0, '0);
        push_ev(1, 24'h00FFFE, 8'h00, '0, '0, '0);
        push_ev(2, 24'h000010, '0, '0, '0, '0);
        push_ev(2, 24'h000011, '0, '0, '0, '0);
        push_ev(3, '0, '0, 16'h2211, 16'hFFFE, 8'h40);
        issue(0, 4'b0010, 0);
        run_and_score(0, 0, 0, 0, cn);
    endtask

    task automatic test_bus_wait();
        int unsigned cn;
        sc_in = 8'h15; pc_in = 16'h5A5A; sp_in = 16'h0400; cb_in = 8'h0E;
        iack_data = 8'h0B; mem[8'h0A] = 8'h34; mem[8'h0B] = 8'h12;
        expect_seq(1, 16'h5A5A, 16'h0400, 8'h15, 8'h0E, 2, 8'h0B);
        issue(0, 4'b0100, 0);
        run_and_score(0, 3, 3, 0, cn);
        n_checks++;
        if (cn != 11) $display("FAIL latency_wait: %0d expected 11", cn);
        else n_pass++;
        // Wait during ACK: the vector byte is only valid once wait drops.
        iack_data = 8'hE6; mem[8'hE6] = 8'h9A; mem[8'hE7] = 8'h78;
        expect_seq(1, 16'h5A5A, 16'h0400, 8'h15, 8'h0E, 2, 8'h0B);
        iack_data = 8'h0B;
        issue(0, 4'b0100, 0);
        iack_data = 8'hE6;
        fork
            run_and_score(0, 1, 2, 0, cn);
            begin
                @(negedge clk); @(negedge clk); #2 iack_data = 8'h0B;
            end
        join
        n_checks++;
        if (cn != 10) $display("FAIL latency_ackwait: %0d expected 10", cn);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int unsigned cn;
        sc_in = 8'h40; pc_in = 16'h1234; sp_in = 16'h2000; cb_in = 8'h05;
        iack_data = 8'h09;
        expect_seq(1, 16'h1234, 16'h2000, 8'h40, 8'h05, 3, 8'h09);
        issue(0, 4'b1000, 0);
        run_and_score(0, 0, 0, 6, cn);
        #1;
        n_checks++;
        if (bi.bus_read !== 1'b1 || bi.bus_address_out !== 24'h000008)
            $display("FAIL vec_lo_state: read=%b addr=%h expected read=1 addr=000008",
                     bi.bus_read, bi.bus_address_out);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, bi.bus_read, bi.bus_write, bi.cpu_iack} !== 4'b0000 || bi.bus_address_out !== '0)
            $display("FAIL async_reset: busy/rd/wr/iack=%b addr=%h expected 0000 000000",
                     {busy, bi.bus_read, bi.bus_write, bi.cpu_iack}, bi.bus_address_out);
        else n_pass++;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b0;
            n_checks++;
            if ({pc_we, sp_we, sc_we, busy} !== 4'b0000)
                $display("FAIL reset_no_we: we/busy=%b expected 0000", {pc_we, sp_we, sc_we, busy});
            else n_pass++;
        end
        expect_seq(1, 16'h1234, 16'h2000, 8'h40, 8'h05, 3, 8'h09);
        issue(0, 4'b1000, 0);
        run_and_score(0, 0, 0, 0, cn);
        n_checks++;
        if (cn != 8) $display("FAIL latency_restart: %0d expected 8", cn);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int unsigned cn;
        sc_in = 8'h00; pc_in = 16'h7000; sp_in = 16'h3000; cb_in = 8'h01;
        iack_data = 8'h40; mem[8'h40] = 8'h00; mem[8'h41] = 8'h90;
        expect_seq(1, 16'h7000, 16'h3000, 8'h00, 8'h01, 1, 8'h40);
        issue(0, 4'b0010, 1);
        run_and_score(0, 0, 0, 0, cn);
        expect_seq(1, 16'h7000, 16'h3000, 8'h00, 8'h01, 1, 8'h40);
        @(negedge clk);
        n_checks++;
        if ({busy, pc_we, sp_we, sc_we} !== 4'b0000)
            $display("FAIL idle_gap: busy/we=%b expected 0000", {busy, pc_we, sp_we, sc_we});
        else n_pass++;
        @(posedge clk);
        #1 instr_boundary = 1'b0;
        run_and_score(0, 0, 0, 0, cn);
        n_checks++;
        if (cn != 8) $display("FAIL latency_b2b: %0d expected 8", cn);
        else n_pass++;
    endtask

    task automatic test_pushcb0();
        int unsigned cn;
        sc_in = 8'h00; pc_in = 16'hCAFE; sp_in = 16'h1000; cb_in = 8'h99;
        iack_data = 8'h30; mem[8'h30] = 8'hEF; mem[8'h31] = 8'hBE;
        expect_seq(0, 16'hCAFE, 16'h1000, 8'h00, 8'h99, 2, 8'h30);
        issue(1, 4'b0100, 0);
        bi0.cpu_irq = 4'b0000;
        iack_data = 8'h30;
        run_and_score(1, 0, 0, 0, cn);
        n_checks++;
        if (cn != 7) $display("FAIL latency_nocb: %0d expected 7", cn);
        else n_pass++;
    endtask

    initial begin
        instr_boundary = 1'b0; ib0 = 1'b0;
        sc_in = '0; pc_in = '0; sp_in = '0; cb_in = '0; iack_data = '0;
        bi.cpu_irq = '0; bi.bus_wait = 1'b0;
        bi0.cpu_irq = '0; bi0.bus_wait = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        test_reset();
        test_maskable();
        test_masking();
        test_sp_wrap();
        test_bus_wait();
        test_reset_mid();
        test_back_to_back();
        test_pushcb0();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
